imem_sram: RTL and testbench

//  Instruction-memory SimpleBus slave feeding the IFU's fetch requests, one request in flight.

---
 rtl/npc_bus_pkg.sv | 16 +
 rtl/delay_lfsr.sv | 16 +
 rtl/imem_sram.sv | 124 ++++++++++++
 tb/tb_imem_sram.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/npc_bus_pkg.sv
// SimpleBus definitions shared by the IFU, LSU and instruction memory:
// slave state encoding, physical memory base and response/error constants.
package npc_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } bus_state_e;

    localparam logic [31:0] PMEM_BASE     = 32'h8000_0000;
    localparam logic        SB_ERR_NONE   = 1'b0;
    localparam logic        SB_ERR_ADDR   = 1'b1;
    localparam logic [31:0] SB_ERR_DATA   = 32'h0000_0000;

endpackage

// File: rtl/delay_lfsr.sv
// Free-running 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) used to draw
// per-request response latencies.
module delay_lfsr #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] lfsr
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr <= SEED;
        else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

endmodule

// File: rtl/imem_sram.sv
// Instruction-memory SimpleBus slave: one fetch in flight, fixed or random
// latency, address range/alignment check and a side load port for the array.
module imem_sram
    import npc_bus_pkg::*;
#(
    parameter int          DEPTH     = 4096,
    parameter logic [31:0] BASE      = PMEM_BASE,
    parameter int          LATENCY   = 1,
    parameter int          RAND_EN   = 0,
    parameter int          RAND_MAX  = 8,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [31:0]              req_addr,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [31:0]              resp_data,
    output logic                     resp_err,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_idx,
    input  logic [31:0]              ld_data
);

    localparam int AW = $clog2(DEPTH);

    bus_state_e  state_q, state_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [7:0]  lfsr;
    logic [7:0]  lat;
    logic [31:0] addr_q;
    logic [31:0] chk_addr;
    logic [31:0] off;
    logic [AW-1:0] idx;
    logic        addr_err;
    logic        capture;
    logic [31:0] rd_word;
    logic        unused_off;
    logic [31:0] mem [DEPTH];

    delay_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .lfsr (lfsr)
    );

    assign lat = (RAND_EN != 0) ? ((lfsr & 8'(RAND_MAX - 1)) + 8'd1) : 8'(LATENCY);

    // With a 1-cycle latency the response is captured on the accept edge,
    // before addr_q holds the address, so check the live bus address then.
    assign chk_addr   = (state_q == IDLE) ? req_addr : addr_q;
    assign off        = chk_addr - BASE;
    assign idx        = off[AW+1:2];
    assign addr_err   = (chk_addr[1:0] != 2'b00) || (off[31:AW+2] != '0);
    assign unused_off = ^off[1:0];

    // A load landing on the captured word in the same edge wins.
    assign rd_word = (ld_en && (ld_idx == idx)) ? ld_data : mem[idx];

    always_ff @(posedge clk) begin
        if (ld_en) mem[ld_idx] <= ld_data;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (lat == 8'd1) begin
                        state_d = RESP;
                        capture = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 7'(lat - 8'd2);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 7'd0) begin
                    state_d = RESP;
                    capture = 1'b1;
                end else begin
                    cnt_d = cnt_q - 7'd1;
                end
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 7'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == IDLE && req_valid) addr_q <= req_addr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_data <= 32'h0;
            resp_err  <= SB_ERR_NONE;
        end else if (capture) begin
            resp_data <= addr_err ? SB_ERR_DATA : rd_word;
            resp_err  <= addr_err ? SB_ERR_ADDR : SB_ERR_NONE;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);

endmodule

// File: tb/tb_imem_sram.sv
// Bench for imem_sram: fixed latency 1 and 4 instances plus a random-latency
// instance, checked against an array model of memory and the address map.
module tb_imem_sram;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid  [3];
    logic        req_ready  [3];
    logic [31:0] req_addr   [3];
    logic        resp_valid [3];
    logic        resp_ready [3];
    logic [31:0] resp_data  [3];
    logic        resp_err   [3];
    logic        ld_en;
    logic [11:0] ld_idx;
    logic [31:0] ld_data;

    logic [31:0] mdl [DEPTH];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imem_sram #(.LATENCY(1)) u_lat1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_data(resp_data[0]), .resp_err(resp_err[0]),
        .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data)
    );

    imem_sram #(.LATENCY(4)) u_lat4 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_data(resp_data[1]), .resp_err(resp_err[1]),
        .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data)
    );

    imem_sram #(.RAND_EN(1), .RAND_MAX(8)) u_rand (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_addr(req_addr[2]),
        .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]),
        .resp_data(resp_data[2]), .resp_err(resp_err[2]),
        .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_err(input logic [31:0] a);
        longint ua;
        ua = longint'(a);
        return (ua % 4 != 0) || (ua < longint'(BASE)) || (ua >= longint'(BASE) + DEPTH * 4);
    endfunction

    function automatic logic [31:0] exp_data(input logic [31:0] a);
        longint ua;
        ua = longint'(a);
        if (exp_err(a)) return 32'h0;
        return mdl[int'((ua - longint'(BASE)) / 4)];
    endfunction

    task automatic load(input int idx, input logic [31:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_idx = 12'(idx); ld_data = d;
        mdl[idx] = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // Issues one request, returns the accept-to-valid latency (accept edge counts
    // as 1) and whether req_ready was seen high while the request was pending.
    task automatic send(input int s, input logic [31:0] a, output int lat, output logic rdy_seen);
        int n;
        @(negedge clk);
        req_valid[s] = 1'b1; req_addr[s] = a;
        n = 0;
        while (req_ready[s] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        req_valid[s] = 1'b0;
        lat = 1;
        rdy_seen = 1'b0;
        while (resp_valid[s] !== 1'b1 && lat < 200) begin
            if (req_ready[s] === 1'b1) rdy_seen = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        if (req_ready[s] === 1'b1) rdy_seen = 1'b1;
    endtask

    task automatic chk_resp(input int s, input logic [31:0] a, input string tag);
        chk({tag, "_valid"}, 32'(resp_valid[s]), 32'd1);
        chk({tag, "_data"}, resp_data[s], exp_data(a));
        chk({tag, "_err"}, 32'(resp_err[s]), 32'(exp_err(a)));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic rdy_seen;
        logic any_valid;
        logic [31:0] a;
        bit seen [9];

        rst = 1'b1; ld_en = 1'b0; ld_idx = '0; ld_data = '0;
        for (int i = 0; i < 3; i++) begin
            req_valid[i] = 1'b0; req_addr[i] = '0; resp_ready[i] = 1'b1;
        end
        for (int i = 0; i < 9; i++) seen[i] = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready[0]), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid[0]), 32'd0);
        chk("rst_resp_data", resp_data[0], 32'd0);
        chk("rst_resp_err", 32'(resp_err[0]), 32'd0);
        rst = 1'b0;

        // Single-cycle latency fetch
        load(0, 32'h0000_0413);
        send(0, BASE, lat, rdy_seen);
        chk("t1_lat", 32'(lat), 32'd1);
        chk_resp(0, BASE, "t1");
        @(posedge clk); #1;
        chk("t1_valid_drop", 32'(resp_valid[0]), 32'd0);
        chk("t1_ready_back", 32'(req_ready[0]), 32'd1);

        // Fixed latency of 4
        load(2, 32'hDEAD_BEEF);
        send(1, BASE + 32'h8, lat, rdy_seen);
        chk("t2_lat", 32'(lat), 32'd4);
        chk("t2_ready_low", 32'(rdy_seen), 32'd0);
        chk_resp(1, BASE + 32'h8, "t2");
        @(posedge clk); #1;
        chk("t2_ready_back", 32'(req_ready[1]), 32'd1);

        // Address errors and the last valid word
        load(DEPTH - 1, 32'h1234_5678);
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: a = BASE + 32'h2;
                1: a = BASE + 32'h4000;
                2: a = 32'h7FFF_FFFC;
                default: a = BASE + 32'h3FFC;
            endcase
            send(0, a, lat, rdy_seen);
            chk("t3_lat", 32'(lat), 32'd1);
            chk_resp(0, a, "t3");
        end
        send(1, BASE + 32'h1, lat, rdy_seen);
        chk("t3_err_lat4", 32'(lat), 32'd4);
        chk_resp(1, BASE + 32'h1, "t3_lat4");

        // Backpressure with a load to the held word
        load(5, 32'h1111_2222);
        resp_ready[1] = 1'b0;
        send(1, BASE + 32'h14, lat, rdy_seen);
        chk_resp(1, BASE + 32'h14, "t4_first");
        @(negedge clk);
        ld_en = 1'b1; ld_idx = 12'd5; ld_data = 32'hCAFE_F00D; mdl[5] = 32'hCAFE_F00D;
        @(posedge clk); #1;
        ld_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_valid", 32'(resp_valid[1]), 32'd1);
            chk("t4_hold_data", resp_data[1], 32'h1111_2222);
            @(posedge clk); #1;
        end
        @(negedge clk);
        resp_ready[1] = 1'b1;
        @(posedge clk); #1;
        chk("t4_release_valid", 32'(resp_valid[1]), 32'd0);
        chk("t4_release_ready", 32'(req_ready[1]), 32'd1);
        @(posedge clk); #1;
        chk("t4_single_hs", 32'(resp_valid[1]), 32'd0);
        send(1, BASE + 32'h14, lat, rdy_seen);
        chk_resp(1, BASE + 32'h14, "t4_new");

        // Load on the same edge the response is captured
        load(6, 32'hAAAA_0006);
        @(negedge clk);
        req_valid[1] = 1'b1; req_addr[1] = BASE + 32'h18;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        ld_en = 1'b1; ld_idx = 12'd6; ld_data = 32'hBBBB_0006; mdl[6] = 32'hBBBB_0006;
        @(posedge clk); #1;
        ld_en = 1'b0;
        chk_resp(1, BASE + 32'h18, "t4_same_edge");
        @(posedge clk); #1;

        // Reset while waiting
        @(negedge clk);
        req_valid[1] = 1'b1; req_addr[1] = BASE;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        for (int s = 0; s < 2; s++) begin
            chk("t5_req_ready", 32'(req_ready[s]), 32'd1);
            chk("t5_resp_valid", 32'(resp_valid[s]), 32'd0);
            chk("t5_resp_data", resp_data[s], 32'd0);
            chk("t5_resp_err", 32'(resp_err[s]), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        any_valid = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (resp_valid[1] !== 1'b0) any_valid = 1'b1;
        end
        chk("t5_no_ghost_resp", 32'(any_valid), 32'd0);
        send(1, BASE + 32'h8, lat, rdy_seen);
        chk("t5_after_lat", 32'(lat), 32'd4);
        chk_resp(1, BASE + 32'h8, "t5_after");

        // Random latency traffic
        for (int i = 0; i < 64; i++) load(i, $urandom);
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 7) == 0) a = $urandom;
            else a = BASE + 32'(4 * $urandom_range(0, 63));
            send(2, a, lat, rdy_seen);
            chk("t6_lat_range", 32'(lat >= 1 && lat <= 8), 32'd1);
            if (lat >= 1 && lat <= 8) seen[lat] = 1'b1;
            chk_resp(2, a, "t6");
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if ($urandom_range(0, 15) == 0) load($urandom_range(0, 63), $urandom);
        end
        for (int v = 1; v <= 8; v++) chk("t6_lat_seen", 32'(seen[v]), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
